machine_arbiter: RTL



---
 rtl/machine_pkg.sv | 33 +++
 rtl/machine_arbiter_if.sv | 32 +++
 rtl/rr_pick2.sv | 13 +
 rtl/machine_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/machine_pkg.sv
// Shared definitions for the S/Y machine: regime codes, arbiter states and
// the latched operation descriptor.
package machine_pkg;

  localparam int unsigned TO_W  = 8;
  localparam int unsigned LEN_W = 4;

  typedef logic [1:0] regime_t;

  localparam regime_t R0 = 2'd0;
  localparam regime_t R1 = 2'd1;
  localparam regime_t R2 = 2'd2;
  localparam regime_t R3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ENTER,
    RUN,
    FINISH
  } arb_state_t;

  // Operation captured from the winning requester at grant time.
  typedef struct packed {
    regime_t          mode;
    logic [LEN_W-1:0] len;
  } arb_op_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/machine_arbiter_if.sv
// Client and control-path signals of the machine arbiter.
interface machine_arbiter_if;
  import machine_pkg::*;

  logic             req0;
  logic             req1;
  regime_t          mode0;
  regime_t          mode1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             err;
  logic             busy;
  regime_t          on;
  logic             start;
  regime_t          regime;
  logic             active;

  modport slave (
    input  req0, req1, mode0, mode1, len0, len1, regime, active,
    output gnt0, gnt1, done0, done1, err, busy, on, start
  );

  modport master (
    output req0, req1, mode0, mode1, len0, len1, regime, active,
    input  gnt0, gnt1, done0, done1, err, busy, on, start
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a tie goes to the requester not served last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid_c,
  output logic pick_c
);

  assign valid_c = req0 | req1;
  assign pick_c  = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/machine_arbiter.sv
// Shares the S/Y machine between two clients: grants round-robin, drives the
// control path's on/start, and reports completion or timeout abort.
module machine_arbiter
  import machine_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  machine_arbiter_if.slave bus
);

  arb_state_t       state_q, state_d;
  arb_op_t          op_q, op_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       err_q, err_d;
  regime_t    on_q, on_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;

  logic             pick_valid_c;
  logic             pick_c;
  arb_op_t          req_op_c;
  logic [LEN_W-1:0] eff_len_c;
  logic [TO_W-1:0]  to_inc_c;
  logic             to_hit_c;

  rr_pick2 u_pick (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .last    (last_q),
    .valid_c (pick_valid_c),
    .pick_c  (pick_c)
  );

  assign req_op_c  = pick_c ? {bus.mode1, bus.len1} : {bus.mode0, bus.len0};
  assign eff_len_c = (op_q.len == '0) ? LEN_W'(1) : op_q.len;
  assign to_inc_c  = to_q + TO_W'(1);
  assign to_hit_c  = (to_inc_c == TO_W'(TIMEOUT));

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    to_d    = to_q;
    done_d  = '0;
    err_d   = 1'b0;
    on_d    = R0;
    start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_d = ISSUE;
          owner_d = pick_c;
          op_d    = req_op_c;
          on_d    = req_op_c.mode;
        end
      end

      ISSUE: begin
        to_d = '0;
        if (op_q.mode == R0) begin
          state_d = FINISH;
          done_d  = onehot2(owner_q);
        end else begin
          state_d = ENTER;
        end
      end

      ENTER: begin
        if (to_hit_c) begin
          state_d = FINISH;
          done_d  = onehot2(owner_q);
          err_d   = 1'b1;
        end else begin
          to_d = to_inc_c;
          if (bus.regime == op_q.mode) begin
            state_d = RUN;
            hold_d  = eff_len_c - LEN_W'(1);
            // Enumerate is launched only if it is not already running.
            start_d = (op_q.mode == R1) ? ~bus.active : (op_q.mode == R2);
          end
        end
      end

      RUN: begin
        if (to_hit_c) begin
          state_d = FINISH;
          done_d  = onehot2(owner_q);
          err_d   = 1'b1;
        end else begin
          to_d = to_inc_c;
          if (op_q.mode == R2 && hold_q != '0) begin
            start_d = 1'b1;
            hold_d  = hold_q - LEN_W'(1);
          end
          // R2 may only finish once its hold window has been fully issued.
          if (bus.regime == R0 && (op_q.mode != R2 || hold_q == '0)) begin
            state_d = FINISH;
            done_d  = onehot2(owner_q);
            start_d = 1'b0;
          end
        end
      end

      FINISH: begin
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    gnt_d  = busy_d ? onehot2(owner_d) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
      to_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      on_q    <= R0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      on_q    <= on_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt0  = gnt_q[0];
  assign bus.gnt1  = gnt_q[1];
  assign bus.done0 = done_q[0];
  assign bus.done1 = done_q[1];
  assign bus.err   = err_q;
  assign bus.on    = on_q;
  assign bus.start = start_q;
  assign bus.busy  = busy_q;

endmodule
